// File: rtl/scr1_dmem_tcm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scr1_dmem_tcm_ctrl_pkg
// Memory-interface types and widths shared by the dmem TCM controller and its
// checker: request command, access width and response enums, the dmem bus
// widths, and two helpers that decode legality and byte-lane enables.
// -----------------------------------------------------------------------------
package scr1_dmem_tcm_ctrl_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // A request is legal for a valid command and a naturally aligned width.
    function automatic logic tcm_req_legal(
        input type_scr1_mem_cmd_e   cmd,
        input type_scr1_mem_width_e width,
        input logic [1:0]           off
    );
        logic cmd_ok;
        logic width_ok;
        cmd_ok = (cmd == SCR1_MEM_CMD_RD) || (cmd == SCR1_MEM_CMD_WR);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  width_ok = 1'b1;
            SCR1_MEM_WIDTH_HWORD: width_ok = ~off[0];
            SCR1_MEM_WIDTH_WORD:  width_ok = (off == 2'b00);
            default:              width_ok = 1'b0;
        endcase
        return cmd_ok & width_ok;
    endfunction

    // Byte-lane enables for an access of the given width at byte offset off.
    function automatic logic [3:0] tcm_byte_en(
        input type_scr1_mem_width_e width,
        input logic [1:0]           off
    );
        logic [3:0] be;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << off;
            SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << off;
            SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage : scr1_dmem_tcm_ctrl_pkg

// File: rtl/scr1_dmem_tcm_ctrl_chk.sv
// -----------------------------------------------------------------------------
// scr1_dmem_tcm_ctrl_chk
// Simulation-only protocol checker: a valid request must carry known command,
// width and low address bits.
// Ports: clk, rst_n, dmem_req, dmem_cmd, dmem_width, dmem_addr_lo (addr[1:0]).
// -----------------------------------------------------------------------------
module scr1_dmem_tcm_ctrl_chk
    import scr1_dmem_tcm_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dmem_req,
    input  type_scr1_mem_cmd_e   dmem_cmd,
    input  type_scr1_mem_width_e dmem_width,
    input  logic [1:0]           dmem_addr_lo
);

`ifndef SYNTHESIS
    // Request qualifiers must never be X/Z while a request is presented.
    a_req_known : assert property (@(posedge clk) disable iff (!rst_n)
        dmem_req |-> !$isunknown({dmem_cmd, dmem_width, dmem_addr_lo}))
        else $error("dmem request with unknown cmd/width/addr[1:0]");
`endif

endmodule : scr1_dmem_tcm_ctrl_chk

// File: rtl/scr1_dmem_tcm_ctrl.sv
// -----------------------------------------------------------------------------
// scr1_dmem_tcm_ctrl
// Terminates one dmem router port and drives a single-port synchronous 32-bit
// SRAM with one-cycle read latency. Requests are always acknowledged; the SRAM
// strobe is issued in the request cycle and the response (OK/ERROR, with
// right-aligned read data) is presented exactly one cycle later.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   dmem_req/_ack/_cmd/_width/_addr/_wdata   request side
//   dmem_rdata, dmem_resp            response side (from response registers)
//   sram_cs/_we/_be/_addr/_wdata     SRAM strobes, combinational from request
//   sram_rdata                       SRAM read data, valid cycle after read
// -----------------------------------------------------------------------------
module scr1_dmem_tcm_ctrl
    import scr1_dmem_tcm_ctrl_pkg::*;
#(
    parameter int SCR1_TCM_AWIDTH = 14
)(
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        dmem_req_ack,
    input  logic                        dmem_req,
    input  type_scr1_mem_cmd_e          dmem_cmd,
    input  type_scr1_mem_width_e        dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e         dmem_resp,
    output logic                        sram_cs,
    output logic                        sram_we,
    output logic [3:0]                  sram_be,
    output logic [SCR1_TCM_AWIDTH-1:0]  sram_addr,
    output logic [31:0]                 sram_wdata,
    input  logic [31:0]                 sram_rdata
);

    logic [1:0] w_off;
    logic       w_legal;
    logic       w_unused;

    logic       r_rsp_vld;
    logic       r_rsp_err;
    logic       r_rsp_rd;
    logic [1:0] r_rsp_off;

    // The SRAM never stalls, so every request is accepted.
    assign dmem_req_ack = 1'b1;

    // Address bits above the TCM window alias; they are decoded by the router.
    assign w_unused = ^dmem_addr[SCR1_DMEM_AWIDTH-1:SCR1_TCM_AWIDTH+2];

    // Request decode and SRAM strobe generation in the request cycle.
    always_comb begin
        w_off      = dmem_addr[1:0];
        w_legal    = tcm_req_legal(dmem_cmd, dmem_width, w_off);
        sram_cs    = dmem_req & w_legal;
        sram_we    = dmem_req & w_legal & (dmem_cmd == SCR1_MEM_CMD_WR);
        sram_be    = tcm_byte_en(dmem_width, w_off);
        sram_addr  = dmem_addr[SCR1_TCM_AWIDTH+1:2];
        sram_wdata = dmem_wdata << {w_off, 3'b000};
    end

    // Response registers: capture the accepted request's outcome for cycle N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_vld <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rsp_rd  <= 1'b0;
            r_rsp_off <= 2'b00;
        end else begin
            r_rsp_vld <= dmem_req;
            if (dmem_req) begin
                r_rsp_err <= ~w_legal;
                r_rsp_rd  <= (dmem_cmd == SCR1_MEM_CMD_RD);
                r_rsp_off <= w_off;
            end else begin
                r_rsp_err <= r_rsp_err;
                r_rsp_rd  <= r_rsp_rd;
                r_rsp_off <= r_rsp_off;
            end
        end
    end

    // Response decode; read data is right-aligned but not masked (LSU extends).
    always_comb begin
        dmem_resp  = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata = 32'h0000_0000;
        if (r_rsp_vld) begin
            if (r_rsp_err) begin
                dmem_resp = SCR1_MEM_RESP_RDY_ER;
            end else begin
                dmem_resp = SCR1_MEM_RESP_RDY_OK;
                if (r_rsp_rd) begin
                    dmem_rdata = sram_rdata >> {r_rsp_off, 3'b000};
                end else begin
                    dmem_rdata = 32'h0000_0000;
                end
            end
        end else begin
            dmem_resp = SCR1_MEM_RESP_NOTRDY;
        end
    end

    scr1_dmem_tcm_ctrl_chk u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr_lo (dmem_addr[1:0])
    );

endmodule : scr1_dmem_tcm_ctrl

// File: tb/tb_scr1_dmem_tcm_ctrl.sv
module tb_scr1_dmem_tcm_ctrl;
    import scr1_dmem_tcm_ctrl_pkg::*;

    localparam int AW = 14;

    logic                 clk;
    logic                 rst_n;
    logic                 dmem_req_ack;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr;
    logic [31:0]          dmem_wdata;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;
    logic                 sram_cs;
    logic                 sram_we;
    logic [3:0]           sram_be;
    logic [AW-1:0]        sram_addr;
    logic [31:0]          sram_wdata;
    logic [31:0]          sram_rdata;

    scr1_dmem_tcm_ctrl #(.SCR1_TCM_AWIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req_ack (dmem_req_ack),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .sram_cs      (sram_cs),
        .sram_we      (sram_we),
        .sram_be      (sram_be),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM, one-cycle read latency.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rd_q;
    assign sram_rdata = rd_q;
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        rd_q = 32'h0;
    end
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                rd_q <= mem[sram_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int                  at;
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%08h exp=%08h", name, cyc, got, want);
        end
    endtask

    // Monitor: compare the response due this cycle, otherwise require IDLE.
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp", 32'(dmem_resp), 32'(e.resp));
            chk("rdata", dmem_rdata, e.rdata);
        end else begin
            chk("idle_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
            chk("idle_rdata", dmem_rdata, 32'h0);
        end
    end

    // Issue one request in the current cycle, check strobes, queue the response.
    task automatic req(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_cs, input logic e_we, input logic [3:0] e_be,
                       input logic [AW-1:0] e_sa, input logic [31:0] e_swd,
                       input type_scr1_mem_resp_e e_resp, input logic [31:0] e_rd);
        exp_t e;
        dmem_req   = 1'b1;
        dmem_cmd   = c;
        dmem_width = w;
        dmem_addr  = a;
        dmem_wdata = wd;
        #1;
        chk("ack", 32'(dmem_req_ack), 32'd1);
        chk("sram_cs", 32'(sram_cs), 32'(e_cs));
        chk("sram_we", 32'(sram_we), 32'(e_we));
        if (e_cs) begin
            chk("sram_be", 32'(sram_be), 32'(e_be));
            chk("sram_addr", 32'(sram_addr), 32'(e_sa));
            if (e_we) chk("sram_wdata", sram_wdata, e_swd);
        end
        e.at = cyc + 1; e.resp = e_resp; e.rdata = e_rd;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        dmem_req = 1'b0;
        #1;
        chk("idle_cs", 32'(sram_cs), 32'd0);
        chk("idle_we", 32'(sram_we), 32'd0);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    localparam type_scr1_mem_resp_e OK = SCR1_MEM_RESP_RDY_OK;
    localparam type_scr1_mem_resp_e ER = SCR1_MEM_RESP_RDY_ER;

    initial begin
        rst_n = 1'b0; dmem_req = 1'b0; dmem_cmd = SCR1_MEM_CMD_RD;
        dmem_width = SCR1_MEM_WIDTH_WORD; dmem_addr = 32'h0; dmem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // WORD write then read back
        req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 4'b1111, 14'd4, 32'hDEADBEEF, OK, 32'h0);
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, 1'b1, 1'b0, 4'b1111, 14'd4, 32'h0, OK, 32'hDEADBEEF);
        // BYTE write into lane 3, read merged word, HWORD reads
        req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h13, 32'h000000A5, 1'b1, 1'b1, 4'b1000, 14'd4, 32'hA5000000, OK, 32'h0);
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, 1'b1, 1'b0, 4'b1111, 14'd4, 32'h0, OK, 32'hA5ADBEEF);
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, 32'h0, 1'b1, 1'b0, 4'b1100, 14'd4, 32'h0, OK, 32'h0000A5AD);
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h11, 32'h0, 1'b0, 1'b0, 4'b0000, 14'd0, 32'h0, ER, 32'h0);
        // Fill words 5 and 6 with mixed widths
        req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h14, 32'h12345678, 1'b1, 1'b1, 4'b1111, 14'd5, 32'h12345678, OK, 32'h0);
        req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h1A, 32'h0000CAFE, 1'b1, 1'b1, 4'b1100, 14'd6, 32'hCAFE0000, OK, 32'h0);
        req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h18, 32'h00000077, 1'b1, 1'b1, 4'b0001, 14'd6, 32'h00000077, OK, 32'h0);
        req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h19, 32'h00000066, 1'b1, 1'b1, 4'b0010, 14'd6, 32'h00006600, OK, 32'h0);
        idle(1);
        // Back-to-back reads, then IDLE
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, 1'b1, 1'b0, 4'b1111, 14'd4, 32'h0, OK, 32'hA5ADBEEF);
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h14, 32'h0, 1'b1, 1'b0, 4'b1111, 14'd5, 32'h0, OK, 32'h12345678);
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h18, 32'h0, 1'b1, 1'b0, 4'b1111, 14'd6, 32'h0, OK, 32'hCAFE6677);
        idle(2);
        // Unmasked byte read, illegal commands/widths, illegal write has no effect
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h19, 32'h0, 1'b1, 1'b0, 4'b0010, 14'd6, 32'h0, OK, 32'h00CAFE66);
        req(SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, 1'b0, 1'b0, 4'b0000, 14'd0, 32'h0, ER, 32'h0);
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_ERROR, 32'h10, 32'h0, 1'b0, 1'b0, 4'b0000, 14'd0, 32'h0, ER, 32'h0);
        req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h12, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0000, 14'd0, 32'h0, ER, 32'h0);
        req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h13, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0000, 14'd0, 32'h0, ER, 32'h0);
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, 1'b1, 1'b0, 4'b1111, 14'd4, 32'h0, OK, 32'hA5ADBEEF);
        // Upper address bits alias into the window
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0001_0014, 32'h0, 1'b1, 1'b0, 4'b1111, 14'd5, 32'h0, OK, 32'h12345678);
        idle(1);

        // Reset while a read response is on the bus: dropped, never replayed
        req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h14, 32'h0, 1'b1, 1'b0, 4'b1111, 14'd5, 32'h0, OK, 32'h0);
        exp_q[exp_q.size()-1].resp = SCR1_MEM_RESP_NOTRDY;
        dmem_req = 1'b0;
        chk("pre_rst_resp", 32'(dmem_resp), 32'(OK));
        chk("pre_rst_rdata", dmem_rdata, 32'h12345678);
        rst_n = 1'b0;
        #1;
        chk("rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        chk("rst_rdata", dmem_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scr1_dmem_tcm_ctrl
